instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 14 +
 rtl/pc_reg.sv | 25 ++
 rtl/instr_fetch.sv | 83 ++++++++
 tb/tb_instr_fetch.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, the NOP
// value held in the instruction register after reset, and the default reset PC.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: reset beats load, load beats increment.
// The increment wraps naturally at 2^32 through the 32-bit adder.
module pc_reg
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic        inc,
  output logic [31:0] pc
);

  always_ff @(posedge clk) begin
    if (reset)
      pc <= RESET_PC;
    else if (load)
      pc <= load_pc;
    else if (inc)
      pc <= pc + 32'd4;
  end

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: reads a combinational ROM at the
// PC, holds the instruction until the consumer accepts it, handles redirects.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        fetch_req,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        misalign
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         redirect_ok;
  logic         redirect_bad;
  logic         pc_inc;

  assign redirect_ok  = redirect && (redirect_pc[1:0] == 2'b00);
  assign redirect_bad = redirect && (redirect_pc[1:0] != 2'b00);
  // Any redirect, aligned or not, cancels an in-flight capture and its increment.
  assign pc_inc       = (state == ST_FETCH) && !redirect;
  assign rom_addr     = pc;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (redirect_ok),
    .load_pc (redirect_pc),
    .inc     (pc_inc),
    .pc      (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      instr       <= NOP_INSTR;
      instr_pc    <= 32'h0000_0000;
      instr_valid <= 1'b0;
      misalign    <= 1'b0;
    end else if (redirect) begin
      state       <= ST_IDLE;
      instr_valid <= 1'b0;
      if (redirect_bad)
        misalign <= 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (fetch_req && !misalign)
            state <= ST_FETCH;
        end
        ST_FETCH: begin
          instr       <= rom_data;
          instr_pc    <= pc;
          instr_valid <= 1'b1;
          state       <= ST_VALID;
        end
        ST_VALID: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= (fetch_req && !misalign) ? ST_FETCH : ST_IDLE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run
// checked against a transaction-level model of the delivered instruction stream.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        fetch_req;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        misalign;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a[31:2] == 30'd0)
      return 32'h0050_0093;
    return {a[31:2], 2'b00} ^ 32'h1357_9BDF;
  endfunction

  assign rom_data = rom_word(rom_addr);

  instr_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .fetch_req   (fetch_req),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .misalign    (misalign)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; fetch_req = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; instr_ready = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    vectors++; if (instr !== 32'h0000_0013) begin miscompares++; $display("FAIL reset_instr: got %h want 00000013", instr); end
    vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
    vectors++; if (misalign !== 1'b0) begin miscompares++; $display("FAIL reset_misalign: got %b want 0", misalign); end
    vectors++; if (rom_addr !== 32'h0) begin miscompares++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
  endtask

  task automatic test_first_fetch();
    do_reset();
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL latency_n1: got %b want 0", instr_valid); end
    step();
    vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL latency_n2: got %b want 1", instr_valid); end
    vectors++; if (instr !== 32'h0050_0093) begin miscompares++; $display("FAIL first_instr: got %h want 00500093", instr); end
    vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL first_instr_pc: got %h want 0", instr_pc); end
    vectors++; if (rom_addr !== 32'h4) begin miscompares++; $display("FAIL first_rom_addr: got %h want 4", rom_addr); end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL first_accept: got %b want 0", instr_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    int seen;
    do_reset();
    exp_pc = 32'h0;
    seen = 0;
    fetch_req = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      vectors++; if (instr_valid !== ((i % 2) == 1)) begin miscompares++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, instr_valid, (i % 2) == 1); end
      if (instr_valid === 1'b1) begin
        vectors++; if (instr_pc !== exp_pc || instr !== rom_word(exp_pc)) begin miscompares++; $display("FAIL b2b_order[%0d]: got pc %h instr %h want pc %h instr %h", i, instr_pc, instr, exp_pc, rom_word(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        seen++;
      end
    end
    fetch_req = 1'b0; instr_ready = 1'b0;
    vectors++; if (seen != 6) begin miscompares++; $display("FAIL b2b_count: got %0d want 6", seen); end
  endtask

  task automatic test_hold();
    logic [31:0] base;
    do_reset();
    base = $urandom() & 32'h0000_FFFC;
    redirect = 1'b1; redirect_pc = base;
    step();
    redirect = 1'b0; fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      fetch_req = 1'($urandom_range(0, 1));
      step();
      vectors++; if (instr_valid !== 1'b1 || instr_pc !== base || instr !== rom_word(base)) begin miscompares++; $display("FAIL hold[%0d]: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", i, instr_valid, instr_pc, instr, base, rom_word(base)); end
    end
    fetch_req = 1'b0; instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL hold_release: got %b want 0", instr_valid); end
  endtask

  task automatic test_redirect_valid();
    do_reset();
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_0100; instr_ready = 1'b1; fetch_req = 1'b1;
    step();
    redirect = 1'b0; instr_ready = 1'b0;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL redir_valid_drop: got %b want 0", instr_valid); end
    vectors++; if (rom_addr !== 32'h100) begin miscompares++; $display("FAIL redir_valid_pc: got %h want 100", rom_addr); end
    step();
    fetch_req = 1'b0;
    step();
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== rom_word(32'h100)) begin miscompares++; $display("FAIL redir_valid_next: got v=%b pc=%h instr=%h want v=1 pc=100 instr=%h", instr_valid, instr_pc, instr, rom_word(32'h100)); end
  endtask

  task automatic test_redirect_fetch();
    do_reset();
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0; fetch_req = 1'b1;
    step();
    fetch_req = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0040;
    step();
    redirect = 1'b0;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL redir_fetch_valid: got %b want 0", instr_valid); end
    vectors++; if (instr !== 32'h0050_0093 || instr_pc !== 32'h0) begin miscompares++; $display("FAIL redir_fetch_keep: got instr=%h pc=%h want 00500093/0", instr, instr_pc); end
    vectors++; if (rom_addr !== 32'h40) begin miscompares++; $display("FAIL redir_fetch_pc: got %h want 40", rom_addr); end
    step();
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL redir_fetch_late: got %b want 0", instr_valid); end
  endtask

  task automatic test_misalign();
    int bad;
    do_reset();
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    step();
    redirect = 1'b0;
    vectors++; if (misalign !== 1'b1) begin miscompares++; $display("FAIL misalign_set: got %b want 1", misalign); end
    vectors++; if (rom_addr !== 32'h4) begin miscompares++; $display("FAIL misalign_pc: got %h want 4", rom_addr); end
    bad = 0;
    fetch_req = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (instr_valid !== 1'b0 || rom_addr !== 32'h4 || misalign !== 1'b1) bad++;
    end
    fetch_req = 1'b0; instr_ready = 1'b0;
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL misalign_ignore: got %0d bad cycles want 0", bad); end
    do_reset();
    vectors++; if (misalign !== 1'b0) begin miscompares++; $display("FAIL misalign_clear: got %b want 0", misalign); end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0; fetch_req = 1'b1; instr_ready = 1'b1;
    step();
    step();
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_first: got v=%b pc=%h want v=1 pc=fffffffc", instr_valid, instr_pc); end
    step();
    step();
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h0050_0093) begin miscompares++; $display("FAIL wrap_second: got v=%b pc=%h instr=%h want v=1 pc=0 instr=00500093", instr_valid, instr_pc, instr); end
    step();
    vectors++; if (rom_addr !== 32'h4) begin miscompares++; $display("FAIL wrap_fetch_addr: got %h want 4", rom_addr); end
    reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    reset = 1'b0; redirect = 1'b0; fetch_req = 1'b0; instr_ready = 1'b0;
    vectors++; if (instr_valid !== 1'b0 || rom_addr !== 32'h0 || instr !== 32'h0000_0013) begin miscompares++; $display("FAIL reset_in_fetch: got v=%b pc=%h instr=%h want v=0 pc=0 instr=00000013", instr_valid, rom_addr, instr); end
  endtask

  // Model: the stream of newly presented instructions follows PC+4 from the
  // last presented address, restarting at each redirect target.
  task automatic test_random();
    logic [31:0] exp_next, held_instr, held_pc, rpc;
    logic        was_valid, rd, rdy;
    do_reset();
    exp_next = 32'h0;
    for (int i = 0; i < 600; i++) begin
      fetch_req   = ($urandom_range(0, 3) != 0);
      instr_ready = 1'($urandom_range(0, 1));
      rd          = ($urandom_range(0, 15) == 0);
      rpc         = ($urandom_range(0, 1) == 1) ? ($urandom() & 32'hFFFF_FFFC) : 32'hFFFF_FFF0;
      redirect    = rd;
      redirect_pc = rpc;
      rdy         = instr_ready;
      was_valid   = instr_valid;
      held_instr  = instr;
      held_pc     = instr_pc;
      step();
      vectors++;
      if (rd) begin
        exp_next = rpc;
        if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rand_redirect[%0d]: got v=%b want 0", i, instr_valid); end
      end else if (was_valid && rdy) begin
        if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rand_accept[%0d]: got v=%b want 0", i, instr_valid); end
      end else if (was_valid) begin
        if (instr_valid !== 1'b1 || instr !== held_instr || instr_pc !== held_pc) begin miscompares++; $display("FAIL rand_stall[%0d]: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", i, instr_valid, instr_pc, instr, held_pc, held_instr); end
      end else if (instr_valid === 1'b1) begin
        if (instr_pc !== exp_next || instr !== rom_word(exp_next)) begin miscompares++; $display("FAIL rand_new[%0d]: got pc=%h instr=%h want pc=%h instr=%h", i, instr_pc, instr, exp_next, rom_word(exp_next)); end
        exp_next = exp_next + 32'd4;
      end else if (misalign !== 1'b0) begin
        miscompares++; $display("FAIL rand_misalign[%0d]: got %b want 0", i, misalign);
      end
    end
    redirect = 1'b0; fetch_req = 1'b0; instr_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_hold();
    test_redirect_valid();
    test_redirect_fetch();
    test_misalign();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
